// File: rtl/synapse_mac_acc.sv
// synapse_mac_acc: synaptic multiply-accumulate for one post-synaptic neuron.
// Spikes are latched per synapse slot during a timestep. On timestep_end the
// spiked set is frozen and its weights are summed, one slot per cycle, into a
// saturating signed accumulator whose result is handed to the neuron stage.
module synapse_mac_acc #(
    parameter int NUM_CONN = 8,
    parameter int ADDR_W   = 12,
    parameter int WEIGHT_W = 16,
    parameter int ACC_W    = 24,
    localparam int IDX_W   = (NUM_CONN > 1) ? $clog2(NUM_CONN) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic                       cfg_en,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic signed [WEIGHT_W-1:0] cfg_weight,
    input  logic                       spike_valid,
    input  logic [ADDR_W-1:0]          spike_addr,
    input  logic                       timestep_end,
    output logic signed [ACC_W-1:0]    acc_out,
    output logic                       acc_valid,
    output logic                       acc_sat,
    output logic                       busy,
    output logic                       ts_overrun
);

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_ACCUM   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                     state;
    logic [NUM_CONN-1:0]        slot_en;
    logic [ADDR_W-1:0]          slot_addr   [NUM_CONN];
    logic signed [WEIGHT_W-1:0] slot_weight [NUM_CONN];
    logic [NUM_CONN-1:0]        pending;
    logic [NUM_CONN-1:0]        pending_nxt;
    logic [NUM_CONN-1:0]        snapshot;
    logic [NUM_CONN-1:0]        spike_hit;
    logic [IDX_W-1:0]           idx;
    logic signed [ACC_W-1:0]    acc;
    logic                       sat;
    logic [ACC_W:0]             step_res;
    logic signed [ACC_W-1:0]    acc_nxt;
    logic                       sat_nxt;
    logic                       cfg_ok;
    logic                       ts_take;

    // Adds a sign-extended weight with one guard bit and clamps to the ACC_W
    // range. The MSB of the result is the clamp flag, the rest is the value.
    function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                               input logic signed [WEIGHT_W-1:0] w);
        logic signed [ACC_W:0] sum;
        logic signed [ACC_W:0] max_v;
        logic signed [ACC_W:0] min_v;
        max_v = {2'b00, {(ACC_W-1){1'b1}}};
        min_v = {2'b11, {(ACC_W-1){1'b0}}};
        sum   = {a[ACC_W-1], a} + {{(ACC_W+1-WEIGHT_W){w[WEIGHT_W-1]}}, w};
        if (sum > max_v)
            return {1'b1, max_v[ACC_W-1:0]};
        else if (sum < min_v)
            return {1'b1, min_v[ACC_W-1:0]};
        else
            return {1'b0, sum[ACC_W-1:0]};
    endfunction

    assign ts_take = timestep_end && (state == S_COLLECT);
    // Writes are only taken while idle and not closing a timestep, so the
    // table never changes under an accumulation pass.
    assign cfg_ok  = cfg_we && (state == S_COLLECT) && !timestep_end
                     && (32'(cfg_idx) < NUM_CONN);

    // Address match of the incoming spike against every valid slot.
    always_comb begin
        spike_hit = '0;
        for (int i = 0; i < NUM_CONN; i++) begin
            if (spike_valid && slot_en[i] && (slot_addr[i] == spike_addr))
                spike_hit[i] = 1'b1;
        end
    end

    // Next pending set: accumulate hits; a reprogrammed slot starts clean.
    always_comb begin
        pending_nxt = pending | spike_hit;
        if (cfg_ok)
            pending_nxt[cfg_idx] = 1'b0;
    end

    // One accumulation step for the slot currently addressed by idx.
    always_comb begin
        step_res = {1'b0, acc};
        if (snapshot[idx])
            step_res = sat_add(acc, slot_weight[idx]);
        acc_nxt = step_res[ACC_W-1:0];
        sat_nxt = sat | step_res[ACC_W];
    end

    // Synapse table: runtime-programmable enable, source address and weight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            slot_en <= '0;
            for (int i = 0; i < NUM_CONN; i++) begin
                slot_addr[i]   <= '0;
                slot_weight[i] <= '0;
            end
        end else if (cfg_ok) begin
            slot_en[cfg_idx]     <= cfg_en;
            slot_addr[cfg_idx]   <= cfg_addr;
            slot_weight[cfg_idx] <= cfg_weight;
        end
    end

    // Double-buffered spike capture: a closing timestep freezes pending into
    // snapshot, and same-cycle spikes already belong to the next timestep.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pending  <= '0;
            snapshot <= '0;
        end else if (ts_take) begin
            snapshot <= pending;
            pending  <= spike_hit;
        end else begin
            pending  <= pending_nxt;
        end
    end

    // Control FSM with registered outputs. The result is registered on the
    // last ACCUM edge so acc_out and acc_valid appear together in DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= S_COLLECT;
            idx        <= '0;
            acc        <= '0;
            sat        <= 1'b0;
            acc_out    <= '0;
            acc_sat    <= 1'b0;
            acc_valid  <= 1'b0;
            busy       <= 1'b0;
            ts_overrun <= 1'b0;
        end else begin
            acc_valid  <= 1'b0;
            ts_overrun <= timestep_end && (state != S_COLLECT);
            case (state)
                S_COLLECT: begin
                    if (timestep_end) begin
                        acc   <= '0;
                        sat   <= 1'b0;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    acc <= acc_nxt;
                    sat <= sat_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(NUM_CONN - 1)) begin
                        acc_out   <= acc_nxt;
                        acc_sat   <= sat_nxt;
                        acc_valid <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_COLLECT;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule
